// File: rtl/simon_pkg.sv
// Shared constants and helpers for the Simon game datapath and controller.
package simon_pkg;

  localparam int SIMON_DEPTH  = 64;
  localparam int SIMON_ADDR_W = 6;

  localparam logic [1:0] SEL_PLAYBACK = 2'b00;
  localparam logic [1:0] SEL_REPEAT   = 2'b01;
  localparam logic [1:0] SEL_DONE     = 2'b10;
  localparam logic [1:0] SEL_RSVD     = 2'b11;

  localparam logic LEVEL_EASY = 1'b0;
  localparam logic LEVEL_HARD = 1'b1;

  // Source of the LED drive
  typedef enum logic [1:0] {
    LED_SW  = 2'd0,
    LED_MEM = 2'd1,
    LED_OFF = 2'd2
  } led_mode_e;

  typedef enum logic [2:0] {
    MODE_INPUT    = 3'd0,
    MODE_PLAYBACK = 3'd1,
    MODE_REPEAT   = 3'd2,
    MODE_DONE     = 3'd3,
    MODE_RSVD     = 3'd4
  } mode_e;

  // Easy accepts any non-zero pattern; hard accepts exactly one lit switch.
  function automatic logic pattern_legal(input logic level, input logic [3:0] p);
    logic [3:0] w_low;
    w_low = p & (p - 4'd1);
    if (level == LEVEL_HARD) return (p != 4'd0) && (w_low == 4'd0);
    return p != 4'd0;
  endfunction

endpackage

// File: rtl/simon_pattern_mem.sv
// Pattern storage: one synchronous write port, one asynchronous read port.
module simon_pattern_mem #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [3:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [3:0]        o_rdata
);

  logic [3:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/simon_datapath.sv
// Simon datapath: pattern memory, stored count, playback/repeat pointers and
// the status flags fed back to the controller.
module simon_datapath
  import simon_pkg::*;
#(
  parameter int DEPTH  = SIMON_DEPTH,
  parameter int ADDR_W = SIMON_ADDR_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level,
  input  logic [3:0] pattern,
  input  logic [1:0] select,
  input  logic       w_en,
  input  logic       clrcount,
  output logic       is_legal,
  output logic       play_gt_count,
  output logic       repeat_eq_play,
  output logic       input_eq_pattern,
  output logic [3:0] pattern_leds
);

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_play_ptr;
  logic [ADDR_W-1:0] r_rep_ptr;

  mode_e             w_mode;
  led_mode_e         w_led_mode;
  logic [ADDR_W:0]   w_play_nxt;
  logic [ADDR_W:0]   w_rep_nxt;
  logic              w_full;
  logic              w_empty;
  logic              w_we;
  logic [ADDR_W-1:0] w_raddr;
  logic [3:0]        w_rdata;

  always_comb begin
    w_mode = MODE_INPUT;
    if (!w_en) begin
      unique case (select)
        SEL_PLAYBACK: w_mode = MODE_PLAYBACK;
        SEL_REPEAT:   w_mode = MODE_REPEAT;
        SEL_DONE:     w_mode = MODE_DONE;
        default:      w_mode = MODE_RSVD;
      endcase
    end
  end

  // Pointer+1 is evaluated one bit wider so it can reach DEPTH
  assign w_play_nxt = {1'b0, r_play_ptr} + 1'b1;
  assign w_rep_nxt  = {1'b0, r_rep_ptr} + 1'b1;
  assign w_full     = (r_count == L_DEPTH);
  assign w_empty    = (r_count == '0);

  assign is_legal         = pattern_legal(level, pattern);
  assign play_gt_count    = (w_play_nxt >= r_count);
  assign repeat_eq_play   = (w_rep_nxt >= r_count);
  assign input_eq_pattern = (w_mode == MODE_REPEAT) && !w_empty && (pattern == w_rdata);

  assign w_raddr = (w_mode == MODE_REPEAT) ? r_rep_ptr : r_play_ptr;
  assign w_we    = (w_mode == MODE_INPUT) && is_legal && !w_full && !rst && !clrcount;

  simon_pattern_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_count[ADDR_W-1:0]),
    .i_wdata (pattern),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_led_mode = LED_OFF;
    unique case (w_mode)
      MODE_INPUT, MODE_REPEAT:  w_led_mode = LED_SW;
      MODE_PLAYBACK, MODE_DONE: w_led_mode = LED_MEM;
      default:                  w_led_mode = LED_OFF;
    endcase
  end

  always_comb begin
    pattern_leds = 4'd0;
    unique case (w_led_mode)
      LED_SW:  pattern_leds = pattern;
      LED_MEM: pattern_leds = w_empty ? 4'd0 : w_rdata;
      default: pattern_leds = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clrcount) begin
      r_count    <= '0;
      r_play_ptr <= '0;
      r_rep_ptr  <= '0;
    end else begin
      unique case (w_mode)
        MODE_INPUT: begin
          r_play_ptr <= '0;
          r_rep_ptr  <= '0;
          if (w_we) r_count <= r_count + 1'b1;
        end
        MODE_PLAYBACK: begin
          if (w_play_nxt < r_count) r_play_ptr <= w_play_nxt[ADDR_W-1:0];
        end
        MODE_REPEAT: begin
          if (input_eq_pattern && (w_rep_nxt < r_count)) r_rep_ptr <= w_rep_nxt[ADDR_W-1:0];
        end
        MODE_DONE: begin
          // Endless replay: wrap after the last stored entry
          r_play_ptr <= play_gt_count ? '0 : w_play_nxt[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_datapath.sv
// Bench for simon_datapath: behavioural model checked every cycle, plus
// directed sequences with hand-computed expectations.
module tb_simon_datapath;

  logic       clk = 1'b0;
  logic       rst, level, w_en, clrcount;
  logic [3:0] pattern;
  logic [1:0] select;
  logic       is_legal, play_gt_count, repeat_eq_play, input_eq_pattern;
  logic [3:0] pattern_leds;

  int checks = 0;
  int errors = 0;

  simon_datapath #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .level            (level),
    .pattern          (pattern),
    .select           (select),
    .w_en             (w_en),
    .clrcount         (clrcount),
    .is_legal         (is_legal),
    .play_gt_count    (play_gt_count),
    .repeat_eq_play   (repeat_eq_play),
    .input_eq_pattern (input_eq_pattern),
    .pattern_leds     (pattern_leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_mem [64];
  int m_count = 0, m_play = 0, m_rep = 0;
  bit m_ok = 0;

  function automatic bit f_legal(logic lv, logic [3:0] p);
    if (lv) return $countones(p) == 1;
    return p != 0;
  endfunction

  // 0 input, 1 playback, 2 repeat, 3 done, 4 reserved
  function automatic int f_mode(logic we, logic [1:0] s);
    if (we) return 0;
    case (s)
      2'b00: return 1;
      2'b01: return 2;
      2'b10: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic bit f_ieq();
    return f_mode(w_en, select) == 2 && m_count != 0 && pattern == m_mem[m_rep];
  endfunction

  always @(posedge clk) begin
    int md;
    bit ieq;
    md  = f_mode(w_en, select);
    ieq = f_ieq();
    if (rst) m_ok = 1;
    if (rst || clrcount) begin
      m_count = 0; m_play = 0; m_rep = 0;
    end else begin
      case (md)
        0: begin
          if (f_legal(level, pattern) && m_count < 64) begin
            m_mem[m_count] = pattern;
            m_count++;
          end
          m_play = 0; m_rep = 0;
        end
        1: if (m_play + 1 < m_count) m_play++;
        2: if (ieq && m_rep + 1 < m_count) m_rep++;
        3: m_play = (m_play + 1 < m_count) ? m_play + 1 : 0;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    int md;
    logic [3:0] e_leds;
    if (m_ok) begin
      md = f_mode(w_en, select);
      if (md == 0 || md == 2) e_leds = pattern;
      else if (md == 4 || m_count == 0) e_leds = 4'd0;
      else e_leds = m_mem[m_play];
      chk("m_is_legal", 32'(is_legal), 32'(f_legal(level, pattern)));
      chk("m_play_gt_count", 32'(play_gt_count), 32'(m_play + 1 >= m_count));
      chk("m_repeat_eq_play", 32'(repeat_eq_play), 32'(m_rep + 1 >= m_count));
      chk("m_input_eq_pattern", 32'(input_eq_pattern), 32'(f_ieq()));
      chk("m_pattern_leds", 32'(pattern_leds), 32'(e_leds));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] seq [3];
    logic [3:0] last;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    rst = 1; w_en = 1; level = 0; pattern = 4'b0101; select = 2'b00; clrcount = 0;
    tick(); tick();
    #2;
    chk("rst_is_legal", 32'(is_legal), 32'd1);
    chk("rst_leds", 32'(pattern_leds), 32'h5);
    chk("rst_play_gt", 32'(play_gt_count), 32'd1);
    chk("rst_rep_eq", 32'(repeat_eq_play), 32'd1);
    chk("rst_ieq", 32'(input_eq_pattern), 32'd0);
    rst = 0;
    tick();                       // writes 0101
    level = 1;
    #2 chk("hard_0101_illegal", 32'(is_legal), 32'd0);
    tick();                       // dropped
    w_en = 0; select = 2'b00;
    #2;
    chk("one_entry_leds", 32'(pattern_leds), 32'h5);
    chk("one_entry_play_gt", 32'(play_gt_count), 32'd1);

    // store 1,2,4 and play back
    clrcount = 1; tick(); clrcount = 0;
    w_en = 1;
    for (int i = 0; i < 3; i++) begin pattern = seq[i]; tick(); end
    w_en = 0; select = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("pb_leds", 32'(pattern_leds), 32'(seq[i > 2 ? 2 : i]));
      chk("pb_play_gt", 32'(play_gt_count), 32'(i >= 2));
      tick();
    end

    // correct repeat
    select = 2'b01;
    for (int i = 0; i < 3; i++) begin
      pattern = seq[i];
      #2;
      chk("rep_ieq", 32'(input_eq_pattern), 32'd1);
      chk("rep_eq_play", 32'(repeat_eq_play), 32'(i == 2));
      tick();
    end

    // wrong second step: rep_ptr must hold at 1
    w_en = 1; pattern = 4'd0; tick();
    w_en = 0; select = 2'b01; pattern = 4'b0001;
    #2 chk("bad_rep_s1", 32'(input_eq_pattern), 32'd1);
    tick();
    pattern = 4'b1000;
    #2 chk("bad_rep_s2", 32'(input_eq_pattern), 32'd0);
    tick();
    pattern = 4'b0010;
    #2 chk("bad_rep_hold", 32'(input_eq_pattern), 32'd1);

    // done: endless replay
    w_en = 1; pattern = 4'd0; tick();
    w_en = 0; select = 2'b10;
    for (int i = 0; i < 7; i++) begin
      #2 chk("done_leds", 32'(pattern_leds), 32'(seq[i % 3]));
      tick();
    end

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      clrcount = ($urandom_range(0, 29) == 0);
      w_en     = ($urandom_range(0, 9) < 4);
      select   = 2'($urandom_range(0, 3));
      level    = 1'($urandom_range(0, 1));
      pattern  = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 0;

    // fill to capacity, then one dropped write
    clrcount = 1; w_en = 1; level = 0; tick(); clrcount = 0;
    last = 4'd0;
    for (int i = 0; i < 64; i++) begin
      pattern = 4'($urandom_range(1, 15));
      last = pattern;
      tick();
    end
    pattern = (last == 4'd1) ? 4'd2 : 4'd1;
    #2 chk("full_still_legal", 32'(is_legal), 32'd1);
    tick();
    w_en = 0; select = 2'b00;
    #2 chk("full_play_gt_start", 32'(play_gt_count), 32'd0);
    for (int i = 0; i < 63; i++) tick();
    #2;
    chk("full_last_leds", 32'(pattern_leds), 32'(last));
    chk("full_last_play_gt", 32'(play_gt_count), 32'd1);

    // clrcount in the middle of playback
    w_en = 1; pattern = 4'd0; tick();
    w_en = 0; select = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    clrcount = 1; tick(); clrcount = 0;
    #2;
    chk("clr_leds", 32'(pattern_leds), 32'd0);
    chk("clr_play_gt", 32'(play_gt_count), 32'd1);
    chk("clr_rep_eq", 32'(repeat_eq_play), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
